// File: rtl/alu181_nibble_seq.sv
// Nibble-serial sequencer: runs a WIDTH-bit 74181 operation through one external
// 4-bit alu181 slice, LS nibble first, with valid/ready on both sides.
module alu181_nibble_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       op_s,
   input  logic             op_m,
   input  logic             op_cn_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout_n,
   output logic             eq,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cn_n,
   input  logic [3:0]       alu_f,
   input  logic             alu_cn4_n,
   input  logic             alu_a_b
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic [3:0]       s_hold;
   logic             m_hold, carry, eq_acc;
   logic [CW-1:0]    cnt;
   logic             last;

   assign last = (cnt == CW'(NIB - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Slice pins are parked at neutral values whenever no nibble is in flight.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      alu_a     = 4'h0;
      alu_b     = 4'h0;
      alu_s     = 4'h0;
      alu_m     = 1'b0;
      alu_cn_n  = 1'b1;
      if (state == RUN) begin
         alu_a    = a_sh[3:0];
         alu_b    = b_sh[3:0];
         alu_s    = s_hold;
         alu_m    = m_hold;
         alu_cn_n = carry;
      end
   end

   // Published result only updates on the final nibble, so it holds through IDLE
   // and an aborted operation never leaks partial state.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         s_hold <= 4'h0;
         m_hold <= 1'b0;
         carry  <= 1'b1;
         eq_acc <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout_n <= 1'b1;
         eq     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh   <= op_a;
               b_sh   <= op_b;
               s_hold <= op_s;
               m_hold <= op_m;
               carry  <= op_cn_n;
               cnt    <= '0;
               eq_acc <= 1'b1;
            end
            RUN: begin
               r_sh   <= {alu_f, r_sh[WIDTH-1:4]};
               a_sh   <= {4'h0, a_sh[WIDTH-1:4]};
               b_sh   <= {4'h0, b_sh[WIDTH-1:4]};
               carry  <= alu_cn4_n;
               eq_acc <= eq_acc & alu_a_b;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  result <= {alu_f, r_sh[WIDTH-1:4]};
                  cout_n <= alu_cn4_n;
                  eq     <= eq_acc & alu_a_b;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Directed bench for alu181_nibble_seq with a behavioural 74181 slice on the alu pins.
module tb_alu181_nibble_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] op_a, op_b, result;
   logic [3:0]   op_s, alu_a, alu_b, alu_s, alu_f;
   logic         op_m, op_cn_n, cout_n, eq, alu_m, alu_cn_n, alu_cn4_n, alu_a_b;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   alu181_nibble_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn_n(op_cn_n),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout_n(cout_n), .eq(eq),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn_n(alu_cn_n),
      .alu_f(alu_f), .alu_cn4_n(alu_cn4_n), .alu_a_b(alu_a_b)
   );

   // Gate-level 74181 equations, active-high data, active-low carry pins.
   function automatic logic [5:0] slice181(input logic [3:0] a, b, s,
                                           input logic m, cn_n);
      logic [3:0] e, d, f;
      logic       c;
      c = ~cn_n;
      for (int i = 0; i < 4; i++) begin
         e[i] = ~((a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2]));
         d[i] = ~(a[i] | (b[i] & s[0]) | (~b[i] & s[1]));
         f[i] = (e[i] ^ d[i]) ^ (m | c);
         c    = ~e[i] | (~d[i] & c);
      end
      return {&f, ~c, f};
   endfunction

   always_comb {alu_a_b, alu_cn4_n, alu_f} = slice181(alu_a, alu_b, alu_s, alu_m, alu_cn_n);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns negedges until out_valid seen and alu_cn_n per RUN cycle.
   task automatic run_op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn_n,
                         output int lat, output logic [3:0] ctr);
      op_a = a; op_b = b; op_s = s; op_m = m; op_cn_n = cn_n;
      in_valid = 1'b1;
      ctr = 4'h0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         if (lat <= 4) ctr[lat-1] = alu_cn_n;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin : main
      int         lat, n;
      logic [3:0] ctr;
      logic       flag;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cn_n = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_hs",   {in_ready, out_valid}, 2'b10);
      chk("rst_res",  {result, cout_n, eq}, {16'h0000, 1'b1, 1'b0});
      chk("rst_pins", {alu_a, alu_b, alu_s, alu_m, alu_cn_n}, {12'h000, 1'b0, 1'b1});

      run_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, lat, ctr);
      chk("add_lat",  lat, 5);
      chk("add_res",  {result, cout_n, eq}, {16'h5555, 1'b1, 1'b0});
      chk("add_cin",  ctr, 4'b1111);
      consume("add");

      run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, lat, ctr);
      chk("wrap_res", {result, cout_n, eq}, {16'h0000, 1'b0, 1'b0});
      chk("wrap_cin", ctr, 4'b0001);
      consume("wrap");

      run_op(16'h5000, 16'h1000, 4'b0110, 1'b0, 1'b0, lat, ctr);
      chk("sub_res",  {result, cout_n, eq}, {16'h4000, 1'b0, 1'b0});
      consume("sub");

      run_op(16'hA5A5, 16'hA5A5, 4'b0110, 1'b0, 1'b1, lat, ctr);
      chk("cmp_eq",   {result, cout_n, eq}, {16'hFFFF, 1'b1, 1'b1});
      consume("cmp_eq");

      run_op(16'hA5A5, 16'hA5A4, 4'b0110, 1'b0, 1'b1, lat, ctr);
      chk("cmp_ne",   {result, cout_n, eq}, {16'h0000, 1'b0, 1'b0});
      consume("cmp_ne");

      // XOR, with a second request raised (and held) while the first is in flight.
      op_a = 16'hF0F0; op_b = 16'hFF00; op_s = 4'b0110; op_m = 1'b1; op_cn_n = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      op_a = 16'h0001; op_b = 16'h0001; op_s = 4'b1001; op_m = 1'b0; op_cn_n = 1'b1;
      flag = 1'b0; n = 1;
      while (!out_valid && n < 20) begin
         flag |= in_ready;
         @(negedge clk);
         n++;
      end
      flag |= in_ready;
      chk("xor_rdy",  flag, 1'b0);
      chk("xor_res",  {result, eq, n[7:0]}, {16'h0FF0, 1'b0, 8'd5});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("xor_idle", {out_valid, in_ready}, 2'b01);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("held_res", {result, cout_n, n[7:0]}, {16'h0002, 1'b1, 8'd4});
      consume("held");

      // Backpressure: everything frozen while out_ready stays low.
      run_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1, lat, ctr);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold", {out_valid, in_ready, cout_n, eq, result}, {4'b1010, 16'h5555});
         @(negedge clk);
      end
      consume("bp");

      // Reset two nibbles into RUN aborts the operation.
      op_a = 16'hFFFF; op_b = 16'h0001; op_s = 4'b1001; op_m = 1'b0; op_cn_n = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_res",  {result, cout_n, eq}, {16'h0000, 1'b1, 1'b0});
      chk("abort_hs",   {in_ready, out_valid, alu_cn_n, alu_a}, 7'b1010000);
      flag = 1'b0;
      repeat (8) begin
         @(negedge clk);
         flag |= out_valid;
      end
      chk("abort_nov",  flag, 1'b0);
      run_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, lat, ctr);
      chk("after_lat",  lat, 5);
      chk("after_res",  {result, cout_n, eq}, {16'h1010, 1'b1, 1'b0});
      consume("after");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
